// File: rtl/draw_pkg.sv
// Shared widths, screen limits and FSM state type for the sprite draw scheduler.
package draw_pkg;

  localparam int X_W      = 9;
  localparam int Y_W      = 8;
  localparam int C_W      = 3;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    PLOT  = 2'd2,
    ACK   = 2'd3
  } draw_state_t;

endpackage

// File: rtl/sprite_draw_scheduler_if.sv
// Requester-side handshake plus the VGA pixel-write port of the sprite draw scheduler.
// The slave modport is the scheduler; the master modport is the surrounding logic.
interface sprite_draw_scheduler_if
  import draw_pkg::*;
#(
  parameter int N_SPRITES = 2
) ();

  logic [N_SPRITES-1:0]     req;
  logic [X_W*N_SPRITES-1:0] req_x;
  logic [Y_W*N_SPRITES-1:0] req_y;
  logic [C_W*N_SPRITES-1:0] req_colour;
  logic [N_SPRITES-1:0]     grant;
  logic [N_SPRITES-1:0]     ack;
  logic [X_W-1:0]           vga_x;
  logic [Y_W-1:0]           vga_y;
  logic [C_W-1:0]           vga_colour;
  logic                     vga_plot;
  logic                     busy;

  modport slave (
    input  req, req_x, req_y, req_colour,
    output grant, ack, vga_x, vga_y, vga_colour, vga_plot, busy
  );

  modport master (
    output req, req_x, req_y, req_colour,
    input  grant, ack, vga_x, vga_y, vga_colour, vga_plot, busy
  );

endinterface

// File: rtl/box_pixel_counter.sv
// Row-major col/row walker over one SPR_W x SPR_H box; start (re)launches a sweep,
// last flags the final pixel, and the counter parks at 0 until the next start.
module box_pixel_counter #(
  parameter int SPR_W = 8,
  parameter int SPR_H = 8,
  localparam int CW   = (SPR_W > 1) ? $clog2(SPR_W) : 1,
  localparam int RW   = (SPR_H > 1) ? $clog2(SPR_H) : 1
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          start,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);

  logic running;

  assign last = running && (col == CW'(SPR_W - 1)) && (row == RW'(SPR_H - 1));

  // Advance col first, wrapping into row, and stop after the final pixel.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      col     <= '0;
      row     <= '0;
      running <= 1'b0;
    end else if (start) begin
      col     <= '0;
      row     <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (last) begin
        col     <= '0;
        row     <= '0;
        running <= 1'b0;
      end else if (col == CW'(SPR_W - 1)) begin
        col <= '0;
        row <= row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Round-robin scheduler sharing one VGA write port among N sprites: erase the old
// box, plot the new one, then ack. Optional macro SPRITE_CLIP_EN suppresses
// vga_plot for pixels beyond the 320x240 screen without changing sweep timing.
module sprite_draw_scheduler
  import draw_pkg::*;
#(
  parameter int             N_SPRITES = 2,
  parameter int             SPR_W     = 8,
  parameter int             SPR_H     = 8,
  parameter logic [C_W-1:0] BG_COLOUR = 3'b000
) (
  input  logic clock,
  input  logic resetn,
  sprite_draw_scheduler_if.slave bus
);

  localparam int IDX_W = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
  localparam int CW    = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RW    = (SPR_H > 1) ? $clog2(SPR_H) : 1;
`ifdef SPRITE_CLIP_EN
  localparam int XF_W  = X_W + 1;
  localparam int YF_W  = Y_W + 1;
`else
  localparam int XF_W  = X_W;
  localparam int YF_W  = Y_W;
`endif

  logic [X_W-1:0]       in_x [N_SPRITES];
  logic [Y_W-1:0]       in_y [N_SPRITES];
  logic [C_W-1:0]       in_c [N_SPRITES];

  draw_state_t          state_q, state_d;
  logic [IDX_W-1:0]     g_q, g_d, sel, cand, rr_ptr_q;
  logic                 any_req;
  logic [N_SPRITES-1:0] grant_q, grant_d, ack_q, ack_d, drawn_valid_q;
  logic [X_W-1:0]       lat_x_q, lat_x_d, sweep_base_x;
  logic [Y_W-1:0]       lat_y_q, lat_y_d, sweep_base_y;
  logic [C_W-1:0]       lat_c_q, lat_c_d, colour_q, colour_d;
  logic [X_W-1:0]       last_x_q [N_SPRITES];
  logic [Y_W-1:0]       last_y_q [N_SPRITES];
  logic [XF_W-1:0]      px_q, px_d, step_x;
  logic [YF_W-1:0]      py_q, py_d, step_y;
  logic                 plot_q, plot_d, sweep_d, busy_q;
  logic                 cnt_start, cnt_last, row_end;
  logic [CW-1:0]        cnt_col;
  logic [RW-1:0]        cnt_row;

  for (genvar i = 0; i < N_SPRITES; i++) begin : g_unpack
    assign in_x[i] = bus.req_x[X_W*i +: X_W];
    assign in_y[i] = bus.req_y[Y_W*i +: Y_W];
    assign in_c[i] = bus.req_colour[C_W*i +: C_W];
  end

  box_pixel_counter #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H)
  ) u_counter (
    .clock  (clock),
    .resetn (resetn),
    .start  (cnt_start),
    .col    (cnt_col),
    .row    (cnt_row),
    .last   (cnt_last)
  );

  assign sweep_base_x = (state_q == ERASE) ? last_x_q[g_q] : lat_x_q;
  assign sweep_base_y = (state_q == ERASE) ? last_y_q[g_q] : lat_y_q;
  assign row_end      = (cnt_col == CW'(SPR_W - 1));
  assign step_x       = row_end ? XF_W'(sweep_base_x) : px_q + XF_W'(1);
  assign step_y       = row_end ? YF_W'(sweep_base_y) + YF_W'(cnt_row) + YF_W'(1) : py_q;

  // Pick the first requester at or after rr_ptr, wrapping around.
  always_comb begin
    any_req = 1'b0;
    sel     = '0;
    cand    = '0;
    for (int i = 0; i < N_SPRITES; i++) begin
      cand = IDX_W'((int'(rr_ptr_q) + i) % N_SPRITES);
      if (!any_req && bus.req[cand]) begin
        any_req = 1'b1;
        sel     = cand;
      end
    end
  end

  // FSM next state plus the pixel the registered VGA outputs show next cycle.
  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    grant_d   = grant_q;
    ack_d     = '0;
    lat_x_d   = lat_x_q;
    lat_y_d   = lat_y_q;
    lat_c_d   = lat_c_q;
    px_d      = '0;
    py_d      = '0;
    colour_d  = '0;
    sweep_d   = 1'b0;
    cnt_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          g_d          = sel;
          grant_d      = '0;
          grant_d[sel] = 1'b1;
          lat_x_d      = in_x[sel];
          lat_y_d      = in_y[sel];
          lat_c_d      = in_c[sel];
          cnt_start    = 1'b1;
          sweep_d      = 1'b1;
          if (drawn_valid_q[sel]) begin
            state_d  = ERASE;
            px_d     = XF_W'(last_x_q[sel]);
            py_d     = YF_W'(last_y_q[sel]);
            colour_d = BG_COLOUR;
          end else begin
            state_d  = PLOT;
            px_d     = XF_W'(in_x[sel]);
            py_d     = YF_W'(in_y[sel]);
            colour_d = in_c[sel];
          end
        end
      end
      ERASE: begin
        sweep_d = 1'b1;
        if (cnt_last) begin
          state_d   = PLOT;
          cnt_start = 1'b1;
          px_d      = XF_W'(lat_x_q);
          py_d      = YF_W'(lat_y_q);
          colour_d  = lat_c_q;
        end else begin
          px_d     = step_x;
          py_d     = step_y;
          colour_d = colour_q;
        end
      end
      PLOT: begin
        if (cnt_last) begin
          state_d = ACK;
          ack_d   = grant_q;
        end else begin
          sweep_d  = 1'b1;
          px_d     = step_x;
          py_d     = step_y;
          colour_d = colour_q;
        end
      end
      ACK: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Write enable for the next pixel, optionally masked outside the visible screen.
  always_comb begin
`ifdef SPRITE_CLIP_EN
    plot_d = sweep_d && (px_d < XF_W'(SCREEN_W)) && (py_d < YF_W'(SCREEN_H));
`else
    plot_d = sweep_d;
`endif
  end

  // State, outputs and per-sprite history; ACK commits the new position.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q       <= IDLE;
      g_q           <= '0;
      grant_q       <= '0;
      ack_q         <= '0;
      lat_x_q       <= '0;
      lat_y_q       <= '0;
      lat_c_q       <= '0;
      px_q          <= '0;
      py_q          <= '0;
      colour_q      <= '0;
      plot_q        <= 1'b0;
      busy_q        <= 1'b0;
      rr_ptr_q      <= '0;
      drawn_valid_q <= '0;
      for (int i = 0; i < N_SPRITES; i++) begin
        last_x_q[i] <= '0;
        last_y_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      lat_x_q  <= lat_x_d;
      lat_y_q  <= lat_y_d;
      lat_c_q  <= lat_c_d;
      px_q     <= px_d;
      py_q     <= py_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= (state_d != IDLE);
      if (state_q == ACK) begin
        last_x_q[g_q]      <= lat_x_q;
        last_y_q[g_q]      <= lat_y_q;
        drawn_valid_q[g_q] <= 1'b1;
        rr_ptr_q           <= (int'(g_q) == N_SPRITES - 1) ? '0 : g_q + IDX_W'(1);
      end
    end
  end

  assign bus.grant      = grant_q;
  assign bus.ack        = ack_q;
  assign bus.vga_x      = px_q[X_W-1:0];
  assign bus.vga_y      = py_q[Y_W-1:0];
  assign bus.vga_colour = colour_q;
  assign bus.vga_plot   = plot_q;
  assign bus.busy       = busy_q;

endmodule
